adder_req_builder: RTL and testbench
====================================

// Module: adder_req_builder
// PURPOSE
//  Initiator side of the adder operand interface. Collects a byte-serial operand stream
//  (valid/ready) and packs it into the 33-bit ins word {cin, w, z, y, x}.
//  Drives ins to the adder, waits out the adder's registered latency and captures sm_r/sm_zero_r.
//  Returns the result on a valid/ready result port. One transaction in flight at a time.
// PARAMETERS
//  LAT       1   adder register stages between a stable ins and a valid sm_r (>=1)
//  CIN_BIT   0   bit of beat 4 (in_data) used as cin
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_data    in   8    operand byte; beat order x, y, z, w, cin
//  in_first   in   1    marks beat 0 of a transaction
//  in_valid   in   1    in_data/in_first valid
//  in_ready   out  1    builder accepts a beat this cycle
//  ins        out  33   packed operand word to adder: [7:0]x [15:8]y [23:16]z [31:24]w [32]cin
//  sm_r       in   10   adder registered sum
//  sm_zero_r  in   1    adder registered zero flag
//  res_data   out  10   captured sum
//  res_zero   out  1    captured zero flag
//  res_valid  out  1    result available
//  res_ready  in   1    consumer takes result
// BEHAVIOUR
//  Reset: state=COLLECT, beat=0, ins=0, in_ready=1, res_data=0, res_zero=0, res_valid=0.
//  COLLECT: in_ready=1. A beat is accepted on in_valid&in_ready.
//   Beats 0-3 write ins[8b+7:8b] for b=beat. Beat 4 writes ins[32]=in_data[CIN_BIT].
//   Other bits of beat 4 are ignored.
//   in_first on an accepted beat forces that beat to slot 0 (resync); partial data is discarded.
//   in_first=0 on a beat accepted at beat==0 is still stored as x (no stall).
//   After beat 4 is accepted: state->WAIT, wcnt=LAT, in_ready=0 next cycle.
//  WAIT: ins is held constant. wcnt decrements each cycle. At wcnt==0, capture sm_r/sm_zero_r
//   into res_data/res_zero and set res_valid=1; state->RESULT.
//   Capture is therefore LAT+1 edges after the edge that loaded beat 4.
//  RESULT: res_valid held; outputs stable until res_ready. On res_valid&res_ready:
//   res_valid=0, beat=0, state->COLLECT.
//   in_ready rises the cycle after the handshake (no bypass).
//  ins is never cleared between transactions; only overwritten beat by beat.
//  Widths: no arithmetic here. Sum range 0..769 fits in 10 bits; res_data copies sm_r unmodified.
//  in_valid during WAIT/RESULT is ignored (in_ready=0); no beat is lost or stored.
//  res_ready while res_valid=0 has no effect.
//  rst_n low at any point: immediate return to reset values; the in-flight transaction is dropped.
//  Simultaneous in_first and beat 4 position: treated as beat 0 (resync wins).
// STRUCTURE
//  adder_pkg holds:
//   - typedef struct packed {w,z,y,x} adder_s1_t
//   - typedef struct packed {cin; adder_s1_t s1} adder_ins_t (33b)
//   - localparam ADDER_BEATS=5
//   - state enum {COLLECT, WAIT, RESULT}
//  Sub-module adder_beat_packer (beat counter + resync + ins field writes) is natural.
//  The top holds the FSM, the latency counter and the result register.
// TESTING (bench instantiates adder_req_builder + adder, LAT=1)
//  1 x=FF y=0C z=FF w=FF cin=01 back-to-back -> res_data=0x301, res_zero=0, res_valid 2 edges after beat 4.
//  2 all beats 00 -> res_data=0, res_zero=1. x=01 y=04 z=00 w=00 cin=00 -> res_data=2 (y[3:2] only).
//  3 Resync: x=10 y=00, then in_first with 05,00,00,00,01 -> res_data=6; earlier partial data is discarded.
//  4 Backpressure: hold res_ready=0 for 10 cycles -> res_valid/res_data stable, in_ready=0;
//    in_valid pulses are ignored; the next transaction after release is correct.
//  5 Assert rst_n low during WAIT -> all outputs at reset values; next transaction runs normally.
//  6 Random in_valid gaps, 200 transactions vs model (x+y[3:2]+z+w+cin) -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types for the adder operand request path.
// Packed operand word layout and builder state encoding.
package adder_pkg;

  localparam int ADDER_BEATS = 5;
  localparam int BEAT_W = 3;

  typedef struct packed {
    logic [7:0] w;
    logic [7:0] z;
    logic [7:0] y;
    logic [7:0] x;
  } adder_s1_t;

  typedef struct packed {
    logic      cin;
    adder_s1_t s1;
  } adder_ins_t;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WAIT    = 2'd1,
    RESULT  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_beat_packer.sv
// Beat counter and operand field writer.
// in_first on an accepted beat resyncs to slot 0.
module adder_beat_packer
  import adder_pkg::*;
#(
  parameter int CIN_BIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       accept,
  input  logic       first,
  input  logic       clear,
  input  logic [7:0] data,
  output adder_ins_t ins,
  output logic       last
);

  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] slot;

  localparam logic [BEAT_W-1:0] LAST_SLOT =
    BEAT_W'(ADDER_BEATS - 1);

  assign slot = first ? '0 : beat;
  assign last = accept && (slot == LAST_SLOT);

  // Beat position: resync, wrap after cin, clear on result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (accept) begin
      beat <= last ? '0 : slot + 1'b1;
    end
  end

  // Field write for the slot of the accepted beat; ins is never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins <= '0;
    end else if (accept) begin
      unique case (1'b1)
        slot == 3'd0: ins.s1.x <= data;
        slot == 3'd1: ins.s1.y <= data;
        slot == 3'd2: ins.s1.z <= data;
        slot == 3'd3: ins.s1.w <= data;
        slot == 3'd4: ins.cin  <= data[CIN_BIT];
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/adder_req_builder.sv
// Initiator side of the adder operand interface.
// Packs a byte stream into ins, waits adder latency, returns the sum.
module adder_req_builder
  import adder_pkg::*;
#(
  parameter int LAT     = 1,
  parameter int CIN_BIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_first,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [32:0] ins,
  input  logic [9:0]  sm_r,
  input  logic        sm_zero_r,
  output logic [9:0]  res_data,
  output logic        res_zero,
  output logic        res_valid,
  input  logic        res_ready
);

  localparam int WCW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  state_t         state_q;
  state_t         state_d;
  logic [WCW-1:0] wcnt;
  logic           accept;
  logic           last;
  logic           cap;
  logic           done;
  adder_ins_t     ins_w;

  assign accept = in_valid && in_ready;
  assign ins    = ins_w;

  adder_beat_packer #(
    .CIN_BIT(CIN_BIT)
  ) u_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .first  (in_first),
    .clear  (done),
    .data   (in_data),
    .ins    (ins_w),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    cap      = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (last) state_d = WAIT;
      end
      WAIT: begin
        if (wcnt == '0) begin
          cap     = 1'b1;
          state_d = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          done    = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Adder latency countdown, loaded as the cin beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (last) begin
      wcnt <= WCW'(LAT);
    end else if (state_q == WAIT && wcnt != '0) begin
      wcnt <= wcnt - 1'b1;
    end
  end

  // Result register: capture after latency, release on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_valid <= 1'b0;
    end else if (cap) begin
      res_data  <= sm_r;
      res_zero  <= sm_zero_r;
      res_valid <= 1'b1;
    end else if (done) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_req_builder.sv
// Directed and randomised bench for adder_req_builder.
// Contains a one-stage registered adder stand-in driving sm_r.
module tb_adder_req_builder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_first;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] ins;
  logic [9:0]  sm_r;
  logic        sm_zero_r;
  logic [9:0]  res_data;
  logic        res_zero;
  logic        res_valid;
  logic        res_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_req_builder #(
    .LAT(1),
    .CIN_BIT(0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ins       (ins),
    .sm_r      (sm_r),
    .sm_zero_r (sm_zero_r),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  function automatic logic [9:0] ref_sum(
    input logic [7:0] x, input logic [7:0] y,
    input logic [7:0] z, input logic [7:0] w,
    input logic c);
    ref_sum = 10'(x) + 10'(y[3:2]) + 10'(z)
            + 10'(w) + 10'(c);
  endfunction

  // Adder stand-in: one register stage from ins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_r      <= '0;
      sm_zero_r <= 1'b1;
    end else begin
      sm_r <= ref_sum(ins[7:0], ins[15:8], ins[23:16],
                      ins[31:24], ins[32]);
      sm_zero_r <= (ref_sum(ins[7:0], ins[15:8],
                    ins[23:16], ins[31:24], ins[32]) == 0);
    end
  end

  task automatic chk(input string tag,
                     input logic [32:0] obs,
                     input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d,
                           input logic f);
    int n;
    n = 0;
    in_data  = d;
    in_first = f;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("beat_timeout", 33'(n), 33'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_txn(input logic [7:0] x,
                          input logic [7:0] y,
                          input logic [7:0] z,
                          input logic [7:0] w,
                          input logic [7:0] c);
    send_beat(x, 1'b1);
    send_beat(y, 1'b0);
    send_beat(z, 1'b0);
    send_beat(w, 1'b0);
    send_beat(c, 1'b0);
  endtask

  task automatic get_result(input string tag,
                            input logic [9:0] ed,
                            input logic ez,
                            input int delay);
    int n;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk({tag, "_timeout"}, 33'(n), 33'd0);
    repeat (delay) @(negedge clk);
    chk({tag, "_data"}, 33'(res_data), 33'(ed));
    chk({tag, "_zero"}, 33'(res_zero), 33'(ez));
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_vld_clr"}, 33'(res_valid), 33'd0);
    chk({tag, "_rdy_up"}, 33'(in_ready), 33'd1);
  endtask

  initial begin
    logic [7:0] rx, ry, rz, rw, rc;
    logic [9:0] es;
    rst_n     = 1'b0;
    in_data   = '0;
    in_first  = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ins", ins, 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd1);
    chk("rst_res_valid", 33'(res_valid), 33'd0);
    chk("rst_res_data", 33'(res_data), 33'd0);
    chk("rst_res_zero", 33'(res_zero), 33'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: max sum, latency check
    send_txn(8'hFF, 8'h0C, 8'hFF, 8'hFF, 8'h01);
    chk("t1_ins", ins, 33'h1_FFFF_0CFF);
    chk("t1_rdy_low", 33'(in_ready), 33'd0);
    chk("t1_vld_e0", 33'(res_valid), 33'd0);
    @(negedge clk);
    chk("t1_vld_e1", 33'(res_valid), 33'd0);
    @(negedge clk);
    chk("t1_vld_e2", 33'(res_valid), 33'd1);
    get_result("t1", 10'h301, 1'b0, 0);

    // 2: zero, y[3:2] only, cin from bit 0 only
    send_txn(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    get_result("t2a", 10'd0, 1'b1, 0);
    send_txn(8'h01, 8'h04, 8'h00, 8'h00, 8'h00);
    get_result("t2b", 10'd2, 1'b0, 0);
    send_txn(8'h00, 8'hF3, 8'h00, 8'h00, 8'hFE);
    get_result("t2c", 10'd0, 1'b1, 0);

    // 3: resync discards partial data
    send_beat(8'h10, 1'b1);
    send_beat(8'h00, 1'b0);
    send_txn(8'h05, 8'h00, 8'h00, 8'h00, 8'h01);
    get_result("t3", 10'd6, 1'b0, 0);

    // 4: backpressure
    send_txn(8'h01, 8'h08, 8'h02, 8'h03, 8'h00);
    repeat (2) @(negedge clk);
    chk("t4_vld", 33'(res_valid), 33'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_first = 1'b1;
      in_data  = 8'hAA;
      @(negedge clk);
      chk("t4_hold_vld", 33'(res_valid), 33'd1);
      chk("t4_hold_data", 33'(res_data), 33'd8);
      chk("t4_hold_rdy", 33'(in_ready), 33'd0);
      chk("t4_hold_ins", ins, 33'h0_0302_0801);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    get_result("t4", 10'd8, 1'b0, 0);
    send_txn(8'h02, 8'h0C, 8'h00, 8'h00, 8'h01);
    get_result("t4n", 10'd6, 1'b0, 0);

    // 5: reset during WAIT
    send_txn(8'h33, 8'h00, 8'h00, 8'h00, 8'h01);
    rst_n = 1'b0;
    #1;
    chk("t5_ins", ins, 33'd0);
    chk("t5_rdy", 33'(in_ready), 33'd1);
    chk("t5_vld", 33'(res_valid), 33'd0);
    chk("t5_data", 33'(res_data), 33'd0);
    chk("t5_zero", 33'(res_zero), 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_no_vld", 33'(res_valid), 33'd0);
    send_txn(8'h11, 8'h00, 8'h22, 8'h00, 8'h01);
    get_result("t5n", 10'h034, 1'b0, 0);

    // 6: random gaps
    for (int t = 0; t < 200; t++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rz = 8'($urandom);
      rw = 8'($urandom);
      rc = 8'($urandom);
      es = ref_sum(rx, ry, rz, rw, rc[0]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(rx, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(ry, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(rz, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(rw, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_beat(rc, 1'b0);
      get_result("t6", es, es == 0,
                 int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
